clz_unit: RTL and testbench

//  - Count-leading-zeros unit for the MIPS CPU datapath; implements the CLZ instruction result.
//  - Returns the number of consecutive 0 bits in operand a, counting from the MSB down.
//  - Result is registered: one clock of latency from operand capture to r.
//  - Sits beside the ALU; the writeback mux selects r for CLZ.

---
 rtl/clz_unit_pkg.sv | 6 +
 rtl/clz_unit_if.sv | 24 ++
 rtl/clz_unit_core.sv | 40 ++++
 rtl/clz_unit.sv | 31 +++
 tb/tb_clz_unit.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/clz_unit_pkg.sv
// Shared constants for the count-leading-zeros unit.
// Operand width and the width of the 0..32 count.
package clz_unit_pkg;
  localparam int DATA_W    = 32;
  localparam int CLZ_RES_W = 6;
endpackage

// File: rtl/clz_unit_if.sv
// Operand/result bundle for the CLZ unit.
// No ready signal: results are never stalled.
interface clz_unit_if;
  import clz_unit_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] a;
  logic              out_valid;
  logic [DATA_W-1:0] r;

  modport master (
    output in_valid,
    output a,
    input  out_valid,
    input  r
  );

  modport slave (
    input  in_valid,
    input  a,
    output out_valid,
    output r
  );
endinterface

// File: rtl/clz_unit_core.sv
// Combinational leading-zero count by halving search.
// Each stage tests the top half of the window and shifts it up.
module clz_core
  import clz_unit_pkg::*;
(
  input  logic [DATA_W-1:0]    a,
  output logic [CLZ_RES_W-1:0] cnt
);

  logic [DATA_W-1:0] x1;
  logic [DATA_W-1:0] x2;
  logic [DATA_W-1:0] x3;
  logic [DATA_W-1:0] x4;
  logic              c4;
  logic              c3;
  logic              c2;
  logic              c1;
  logic              c0;
  logic              zero;

  // Halving search 16/8/4/2/1; all-zero operand overrides to 32.
  always_comb begin
    c4   = (a[31:16] == 16'h0);
    x1   = c4 ? {a[15:0], 16'h0} : a;
    c3   = (x1[31:24] == 8'h0);
    x2   = c3 ? {x1[23:0], 8'h0} : x1;
    c2   = (x2[31:28] == 4'h0);
    x3   = c2 ? {x2[27:0], 4'h0} : x2;
    c1   = (x3[31:30] == 2'h0);
    x4   = c1 ? {x3[29:0], 2'h0} : x3;
    c0   = ~x4[31];
    zero = (a == '0);
    if (zero) begin
      cnt = 6'd32;
    end else begin
      cnt = {1'b0, c4, c3, c2, c1, c0};
    end
  end

endmodule

// File: rtl/clz_unit.sv
// CLZ unit: registered leading-zero count, one result per cycle.
// Count is zero-extended into the full result word.
module clz_unit
  import clz_unit_pkg::*;
(
  input logic       clk,
  input logic       rst,
  clz_unit_if.slave bus
);

  logic [CLZ_RES_W-1:0] cnt;

  clz_core u_core (
    .a   (bus.a),
    .cnt (cnt)
  );

  // Result register; r holds its value on idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.r         <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.r <= {{(DATA_W-CLZ_RES_W){1'b0}}, cnt};
      end
    end
  end

endmodule

// File: tb/tb_clz_unit.sv
// Self-checking bench for clz_unit.
// Results are compared against a bit-scan reference.
module tb_clz_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  clz_unit_if bus ();

  clz_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_clz(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) break;
      n++;
    end
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.a = 32'h0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (bus.r !== 32'd0 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset: r=%0d ov=%b exp r=0 ov=0",
                 bus.r, bus.out_valid);
      end
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_stream();
    logic [31:0] va [8];
    int          ve [8];
    va = '{32'h0000f000, 32'h7fffffff, 32'h07ffffff,
           32'h00000000, 32'h77777777, 32'h80000000,
           32'h00000001, 32'hffffffff};
    ve = '{16, 1, 5, 32, 1, 0, 31, 0};
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.a = va[i];
      step();
      checks++;
      if (bus.r !== 32'(ve[i]) || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stream a=%h: r=%0d ov=%b exp r=%0d ov=1",
                 va[i], bus.r, bus.out_valid, ve[i]);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_hold();
    bus.in_valid = 1'b1;
    bus.a = 32'h00010000;
    step();
    checks++;
    if (bus.r !== 32'd15 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL hold_load: r=%0d ov=%b exp r=15 ov=1",
               bus.r, bus.out_valid);
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.a = $urandom;
      step();
      checks++;
      if (bus.r !== 32'd15 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold: r=%0d ov=%b exp r=15 ov=0",
                 bus.r, bus.out_valid);
      end
    end
  endtask

  task automatic test_walking_one();
    logic [31:0] v;
    for (int k = 0; k < 32; k++) begin
      v = 32'd1 << k;
      bus.in_valid = 1'b1;
      bus.a = v;
      step();
      checks++;
      if (bus.r !== 32'(31 - k) || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL walk k=%0d: r=%0d ov=%b exp r=%0d",
                 k, bus.r, bus.out_valid, 31 - k);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] v;
    int          exp_r;
    bit          vld;
    int          last_r;
    last_r = int'(bus.r);
    for (int i = 0; i < 300; i++) begin
      v = $urandom >> $urandom_range(0, 31);
      vld = ($urandom_range(0, 3) != 0);
      bus.in_valid = vld;
      bus.a = v;
      exp_r = vld ? ref_clz(v) : last_r;
      step();
      checks++;
      if (bus.r !== 32'(exp_r) || bus.out_valid !== vld) begin
        errors++;
        $display("FAIL random a=%h v=%b: r=%0d ov=%b exp r=%0d",
                 v, vld, bus.r, bus.out_valid, exp_r);
      end
      last_r = exp_r;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_stream();
    bus.in_valid = 1'b1;
    bus.a = 32'h0000ffff;
    step();
    checks++;
    if (bus.r !== 32'd16) begin
      errors++;
      $display("FAIL mid_pre: r=%0d exp 16", bus.r);
    end
    rst = 1'b1;
    bus.a = 32'h00000001;
    step();
    checks++;
    if (bus.r !== 32'd0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst: r=%0d ov=%b exp r=0 ov=0",
               bus.r, bus.out_valid);
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    step();
    checks++;
    if (bus.r !== 32'd0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_lost: r=%0d ov=%b exp r=0 ov=0",
               bus.r, bus.out_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.a = '0;
    #1;
    test_reset();
    test_stream();
    test_hold();
    test_walking_one();
    test_random();
    test_reset_mid_stream();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
